// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: shared types and default latencies for the hazard/stall controller
package hazard_stall_ctrl_pkg;
  localparam int SB_RW = 8;
  localparam int SB_CW = 8;
  localparam int DEF_LOAD_LAT = 1;
  localparam int DEF_WB_LAT = 3;
  localparam int DEF_BR_EXTRA = 1;
  localparam int DEF_MAX_WAIT = 15;
  typedef enum logic [1:0] {IDLE, WAIT, ERR} mem_state_e;
  // cnt runs BR_EXTRA past the non-branch latency so a branch reader ages out too
  typedef struct packed {
    logic valid;
    logic [SB_RW-1:0] rd;
    logic [SB_CW-1:0] cnt;
  } sb_entry_t;
endpackage

// File: rtl/hazard_stall_ctrl_mem_wait_fsm.sv
// mem_wait_fsm: freezes the pipeline during data-memory wait states, with a sticky timeout
module mem_wait_fsm
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            mem_req,
  input  logic            dmem_ready,
  output logic            freeze,
  output logic            mem_err,
  output logic [CNTW-1:0] wait_cnt
);
  mem_state_e state, state_n;
  logic [CNTW-1:0] cnt_n;
  logic freeze_raw;
  always_ff @(posedge clk)
    if (!nrst) begin
      state <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      wait_cnt <= cnt_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = wait_cnt;
    freeze_raw = 1'b0;
    case (state)
      IDLE: if (mem_req && !dmem_ready) begin
        freeze_raw = 1'b1;
        state_n = WAIT;
        cnt_n = CNTW'(1);
      end
      WAIT: begin
        freeze_raw = !dmem_ready;
        if (dmem_ready) begin
          state_n = IDLE;
          cnt_n = '0;
        end else if (wait_cnt == CNTW'(MAX_WAIT)) state_n = ERR;
        else cnt_n = wait_cnt + 1'b1;
      end
      ERR: freeze_raw = 1'b1;
      default: state_n = IDLE;
    endcase
  end
  assign freeze = nrst & freeze_raw;
  assign mem_err = state == ERR;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage scoreboard hazard detection driving stall, bubble and memory-wait freeze
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int NREG = 32,
  parameter int RW = $clog2(NREG),
  parameter int DEPTH = 4,
  parameter int FWD_EN = 1,
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int WB_LAT = DEF_WB_LAT,
  parameter int BR_EXTRA = DEF_BR_EXTRA,
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            id_valid,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [RW-1:0]   id_rd,
  input  logic            id_we,
  input  logic            id_is_load,
  input  logic            id_is_branch,
  input  logic            flush,
  input  logic            mem_req,
  input  logic            dmem_ready,
  output logic            stall_f,
  output logic            bubble_d,
  output logic            freeze,
  output logic            mem_err,
  output logic [CNTW-1:0] wait_cnt
);
  sb_entry_t sb [DEPTH];
  sb_entry_t ins;
  logic [SB_CW-1:0] need1, need2;
  logic hazard, stall_raw;
  mem_wait_fsm #(.MAX_WAIT(MAX_WAIT), .CNTW(CNTW)) u_mem (
    .clk(clk), .nrst(nrst), .mem_req(mem_req), .dmem_ready(dmem_ready),
    .freeze(freeze), .mem_err(mem_err), .wait_cnt(wait_cnt)
  );
  function automatic sb_entry_t aged(input sb_entry_t e);
    return '{valid: e.valid, rd: e.rd, cnt: e.cnt == '0 ? '0 : e.cnt - 1'b1};
  endfunction
  function automatic logic src_hazard(input logic [RW-1:0] rs, input logic use_rs,
                                      input logic br, input logic [SB_CW-1:0] need);
    return use_rs && rs != '0 && (br ? need != '0 : need > SB_CW'(BR_EXTRA));
  endfunction
  // walk oldest to youngest so the youngest matching writer wins
  always_comb begin
    need1 = '0;
    need2 = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      need1 = sb[i].valid && sb[i].rd == SB_RW'(id_rs1) ? sb[i].cnt : need1;
      need2 = sb[i].valid && sb[i].rd == SB_RW'(id_rs2) ? sb[i].cnt : need2;
    end
  end
  assign hazard = src_hazard(id_rs1, id_use_rs1, id_is_branch, need1)
                | src_hazard(id_rs2, id_use_rs2, id_is_branch, need2);
  assign stall_raw = id_valid & hazard & ~flush;
  assign stall_f = nrst & ~freeze & stall_raw;
  assign bubble_d = nrst & ~freeze & (stall_raw | flush);
  assign ins.valid = id_valid & id_we & (id_rd != '0) & ~stall_raw & ~flush;
  assign ins.rd = SB_RW'(id_rd);
  assign ins.cnt = SB_CW'(FWD_EN != 0 ? (id_is_load ? LOAD_LAT : 0) + BR_EXTRA : WB_LAT + BR_EXTRA);
  always_ff @(posedge clk)
    if (!nrst) sb <= '{default: '0};
    else if (!freeze) begin
      sb[0] <= ins;
      for (int i = 1; i < DEPTH; i++) sb[i] <= aged(sb[i-1]);
    end
endmodule
